// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter.
// Holds the FSM state type, default parameter values and the watchdog
// counter width used by wb_rr_arbiter and wb_arb_watchdog.
`timescale 1ns/1ps
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam int          CNT_W        = 8;
  localparam int          DEF_TIMEOUT  = 255;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Slave-acknowledge watchdog for wb_rr_arbiter.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : clear the wait count (grant entry or accepted ack)
//   inc        : count one more un-acknowledged strobe cycle
//   expire     : count has reached TIMEOUT-1 (registered count compare)
`timescale 1ns/1ps
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Compare on the registered count so the expiry decision never depends
  // combinationally on the slave bus it gates.
  assign expire = (count_q == LIMIT);

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone classic round-robin arbiter with an ack watchdog.
// Ports:
//   wb_clk_i, wb_rst_ni          : clock, asynchronous active-low reset
//   m0_* / m1_*                  : master ports (cyc/stb/we/sel/adr/dat in,
//                                  dat/ack/err out)
//   s_*                          : shared slave bus
//   grant_o                      : one-hot owner (00 = idle); mirrors FSM state
//   timeout_o                    : one-cycle pulse when an access times out
// Handshake: a beat completes in a cycle where the owner's stb and s_ack_i
// are both high; s_ack_i outside an owner strobe is ignored. A beat that
// waits TIMEOUT strobe cycles without ack ends with err instead of ack.
`timescale 1ns/1ps
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int          TIMEOUT  = DEF_TIMEOUT,
  parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  arb_state_e state_q, state_d;
  logic       last_m1_q;    // 1: master 1 was served most recently
  logic       expire;
  logic       timeout;
  logic       ack_valid;
  logic       grant_entry;

  always_comb begin
    state_d   = state_q;
    timeout   = 1'b0;
    ack_valid = 1'b0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    m0_dat_o  = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_dat_o  = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    grant_o   = 2'b00;
    timeout_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_m1_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0: begin
        timeout   = m0_stb_i & ~s_ack_i & expire;
        ack_valid = m0_stb_i & s_ack_i;
        s_cyc_o   = m0_cyc_i & ~timeout;
        s_stb_o   = m0_stb_i & ~timeout;
        s_we_o    = m0_we_i;
        s_sel_o   = m0_sel_i;
        s_adr_o   = m0_adr_i;
        s_dat_o   = m0_dat_i;
        m0_ack_o  = ack_valid;
        m0_err_o  = timeout;
        m0_dat_o  = timeout ? ERR_DATA : s_dat_i;
        grant_o   = 2'b01;
        timeout_o = timeout;
        if (!m0_cyc_i || timeout) state_d = IDLE;
      end
      GNT1: begin
        timeout   = m1_stb_i & ~s_ack_i & expire;
        ack_valid = m1_stb_i & s_ack_i;
        s_cyc_o   = m1_cyc_i & ~timeout;
        s_stb_o   = m1_stb_i & ~timeout;
        s_we_o    = m1_we_i;
        s_sel_o   = m1_sel_i;
        s_adr_o   = m1_adr_i;
        s_dat_o   = m1_dat_i;
        m1_ack_o  = ack_valid;
        m1_err_o  = timeout;
        m1_dat_o  = timeout ? ERR_DATA : s_dat_i;
        grant_o   = 2'b10;
        timeout_o = timeout;
        if (!m1_cyc_i || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_entry = (state_q == IDLE) && (state_d != IDLE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      last_m1_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (grant_entry) last_m1_q <= (state_d == GNT1);
    end
  end

  wb_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .clr   (grant_entry | ack_valid),
    .inc   (s_stb_o & ~s_ack_i),
    .expire(expire)
  );

endmodule
